// File: rtl/dma_rd_arbiter.sv
// Two-port round-robin front end that shares a single axi_dma_rd engine between
// the weight loader (port 0) and the activation loader (port 1).

module dma_rd_arb_port #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BT = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [BT-1:0] num_trans,
  input  logic [AW-1:0] start_addr,
  input  logic          owned,
  input  logic          done,
  input  logic [DW-1:0] dma_data,
  input  logic          dma_vld,
  input  logic [BT-1:0] dma_cnt,
  output logic          pending,
  output logic          err,
  output logic [BT-1:0] req_num,
  output logic [AW-1:0] req_addr,
  output logic [DW-1:0] data_o,
  output logic          data_vld_o,
  output logic [BT-1:0] data_cnt_o
);
  // A start that lands on this port's done cycle refills the slot being freed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 1'b0;
      err      <= 1'b0;
      req_num  <= '0;
      req_addr <= '0;
    end else begin
      err <= start & pending & ~done;
      if (start && (!pending || done)) begin
        pending  <= 1'b1;
        req_num  <= num_trans;
        req_addr <= start_addr;
      end else if (done) begin
        pending <= 1'b0;
      end
    end
  end

  assign data_o     = dma_data;
  assign data_vld_o = dma_vld & owned;
  assign data_cnt_o = owned ? dma_cnt : '0;
endmodule

module dma_rd_arbiter #(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int BITS_TRANS   = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rq0_start,
  input  logic [BITS_TRANS-1:0]   rq0_num_trans,
  input  logic [AXI_WIDTH_AD-1:0] rq0_start_addr,
  output logic                    rq0_pending,
  output logic                    rq0_err,
  output logic [AXI_WIDTH_DA-1:0] rq0_data_o,
  output logic                    rq0_data_vld_o,
  output logic [BITS_TRANS-1:0]   rq0_data_cnt_o,
  output logic                    rq0_done_o,
  input  logic                    rq1_start,
  input  logic [BITS_TRANS-1:0]   rq1_num_trans,
  input  logic [AXI_WIDTH_AD-1:0] rq1_start_addr,
  output logic                    rq1_pending,
  output logic                    rq1_err,
  output logic [AXI_WIDTH_DA-1:0] rq1_data_o,
  output logic                    rq1_data_vld_o,
  output logic [BITS_TRANS-1:0]   rq1_data_cnt_o,
  output logic                    rq1_done_o,
  output logic                    dma_start,
  output logic [BITS_TRANS-1:0]   dma_num_trans,
  output logic [AXI_WIDTH_AD-1:0] dma_start_addr,
  input  logic [AXI_WIDTH_DA-1:0] dma_data_i,
  input  logic                    dma_data_vld_i,
  input  logic [BITS_TRANS-1:0]   dma_data_cnt_i,
  input  logic                    dma_done_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, ZERO} state_t;

  state_t state, state_nxt;
  logic   owner, last_grant, pick, pick_own;

  logic [1:0]                       start, pending, err, owned, done, vld_o;
  logic [1:0][BITS_TRANS-1:0]       num_in, req_num, cnt_o;
  logic [1:0][AXI_WIDTH_AD-1:0]     addr_in, req_addr;
  logic [1:0][AXI_WIDTH_DA-1:0]     data_o;

  assign start   = {rq1_start, rq0_start};
  assign num_in  = {rq1_num_trans, rq0_num_trans};
  assign addr_in = {rq1_start_addr, rq0_start_addr};

  for (genvar n = 0; n < 2; n++) begin : g_port
    dma_rd_arb_port #(.AW(AXI_WIDTH_AD), .DW(AXI_WIDTH_DA), .BT(BITS_TRANS)) u_port (
      .clk        (clk),
      .rst        (rst),
      .start      (start[n]),
      .num_trans  (num_in[n]),
      .start_addr (addr_in[n]),
      .owned      (owned[n]),
      .done       (done[n]),
      .dma_data   (dma_data_i),
      .dma_vld    (dma_data_vld_i),
      .dma_cnt    (dma_data_cnt_i),
      .pending    (pending[n]),
      .err        (err[n]),
      .req_num    (req_num[n]),
      .req_addr   (req_addr[n]),
      .data_o     (data_o[n]),
      .data_vld_o (vld_o[n]),
      .data_cnt_o (cnt_o[n])
    );
  end

  always_comb begin
    state_nxt = state;
    pick      = 1'b0;
    if (&pending)        pick_own = ~last_grant;
    else if (pending[0]) pick_own = 1'b0;
    else                 pick_own = 1'b1;
    case (state)
      IDLE:  if (|pending) begin
               pick      = 1'b1;
               state_nxt = (req_num[pick_own] == '0) ? ZERO : ISSUE;
             end
      ISSUE: state_nxt = BUSY;
      BUSY:  if (dma_done_i) state_nxt = IDLE;
      ZERO:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Zero-length requests complete from ZERO without touching the DMA.
    for (int n = 0; n < 2; n++) begin
      owned[n] = (state == BUSY) && (owner == 1'(n));
      done[n]  = (owner == 1'(n)) && ((state == BUSY && dma_done_i) || state == ZERO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      dma_num_trans  <= '0;
      dma_start_addr <= '0;
    end else begin
      state <= state_nxt;
      if (pick) begin
        owner          <= pick_own;
        last_grant     <= pick_own;
        dma_num_trans  <= req_num[pick_own];
        dma_start_addr <= req_addr[pick_own];
      end
    end
  end

  assign dma_start = (state == ISSUE);

  assign rq0_pending    = pending[0];
  assign rq1_pending    = pending[1];
  assign rq0_err        = err[0];
  assign rq1_err        = err[1];
  assign rq0_data_o     = data_o[0];
  assign rq1_data_o     = data_o[1];
  assign rq0_data_vld_o = vld_o[0];
  assign rq1_data_vld_o = vld_o[1];
  assign rq0_data_cnt_o = cnt_o[0];
  assign rq1_data_cnt_o = cnt_o[1];
  assign rq0_done_o     = done[0];
  assign rq1_done_o     = done[1];
endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Directed bench for dma_rd_arbiter: the bench plays the DMA engine and checks
// grant order, routing, error pulses, zero-length requests and reset recovery.

module tb_dma_rd_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        rq0_start, rq1_start;
  logic [17:0] rq0_num_trans, rq1_num_trans;
  logic [31:0] rq0_start_addr, rq1_start_addr;
  logic        rq0_pending, rq1_pending, rq0_err, rq1_err;
  logic [31:0] rq0_data_o, rq1_data_o;
  logic        rq0_data_vld_o, rq1_data_vld_o, rq0_done_o, rq1_done_o;
  logic [17:0] rq0_data_cnt_o, rq1_data_cnt_o;
  logic        dma_start;
  logic [17:0] dma_num_trans;
  logic [31:0] dma_start_addr;
  logic [31:0] dma_data_i;
  logic        dma_data_vld_i, dma_done_i;
  logic [17:0] dma_data_cnt_i;

  int n_cmp = 0, n_err = 0;
  int n_start = 0, n_vld0 = 0, n_vld1 = 0, n_done0 = 0, n_done1 = 0;

  dma_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .rq0_start(rq0_start), .rq0_num_trans(rq0_num_trans), .rq0_start_addr(rq0_start_addr),
    .rq0_pending(rq0_pending), .rq0_err(rq0_err), .rq0_data_o(rq0_data_o),
    .rq0_data_vld_o(rq0_data_vld_o), .rq0_data_cnt_o(rq0_data_cnt_o), .rq0_done_o(rq0_done_o),
    .rq1_start(rq1_start), .rq1_num_trans(rq1_num_trans), .rq1_start_addr(rq1_start_addr),
    .rq1_pending(rq1_pending), .rq1_err(rq1_err), .rq1_data_o(rq1_data_o),
    .rq1_data_vld_o(rq1_data_vld_o), .rq1_data_cnt_o(rq1_data_cnt_o), .rq1_done_o(rq1_done_o),
    .dma_start(dma_start), .dma_num_trans(dma_num_trans), .dma_start_addr(dma_start_addr),
    .dma_data_i(dma_data_i), .dma_data_vld_i(dma_data_vld_i),
    .dma_data_cnt_i(dma_data_cnt_i), .dma_done_i(dma_done_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst) begin
    if (dma_start)      n_start++;
    if (rq0_data_vld_o) n_vld0++;
    if (rq1_data_vld_o) n_vld1++;
    if (rq0_done_o)     n_done0++;
    if (rq1_done_o)     n_done1++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int id, input logic [17:0] num, input logic [31:0] addr);
    if (id == 0) begin rq0_start = 1'b1; rq0_num_trans = num; rq0_start_addr = addr; end
    else         begin rq1_start = 1'b1; rq1_num_trans = num; rq1_start_addr = addr; end
  endtask

  // Acts as the DMA for one grant: waits for dma_start, streams num beats, pulses done.
  task automatic xfer(input int id, input int num, input logic [31:0] addr,
                      input bit rearm, input int rnum, input logic [31:0] raddr);
    int k = 0;
    while (!dma_start && k < 20) begin tick(); k++; end
    chk($sformatf("dma_start p%0d", id), dma_start, 1);
    chk($sformatf("dma_num p%0d", id), dma_num_trans, num);
    chk($sformatf("dma_addr p%0d", id), dma_start_addr, addr);
    tick();
    for (int i = 0; i < num; i++) begin
      dma_data_vld_i = 1'b1; dma_data_i = 32'hA000 + i; dma_data_cnt_i = 18'(i + 1);
      #1;
      chk("vld_owner", id ? rq1_data_vld_o : rq0_data_vld_o, 1);
      chk("vld_other", id ? rq0_data_vld_o : rq1_data_vld_o, 0);
      chk("cnt_owner", id ? rq1_data_cnt_o : rq0_data_cnt_o, i + 1);
      chk("data_owner", id ? rq1_data_o : rq0_data_o, 32'hA000 + i);
      tick();
    end
    dma_data_vld_i = 1'b0; dma_done_i = 1'b1;
    if (rearm) req(id, 18'(rnum), raddr);
    #1;
    chk("done_owner", id ? rq1_done_o : rq0_done_o, 1);
    chk("done_other", id ? rq0_done_o : rq1_done_o, 0);
    tick();
    dma_done_i = 1'b0; rq0_start = 1'b0; rq1_start = 1'b0;
    chk("pending_after_done", id ? rq1_pending : rq0_pending, rearm);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    int s0, v0, v1, d1;
    rst = 1'b1;
    rq0_start = 0; rq0_num_trans = 0; rq0_start_addr = 0;
    rq1_start = 0; rq1_num_trans = 0; rq1_start_addr = 0;
    dma_data_i = 0; dma_data_vld_i = 0; dma_data_cnt_i = 0; dma_done_i = 0;
    tick(); tick(); rst = 1'b0;

    chk("rst_pending0", rq0_pending, 0);
    chk("rst_pending1", rq1_pending, 0);
    chk("rst_err", {rq0_err, rq1_err}, 0);
    chk("rst_dma_start", dma_start, 0);
    chk("rst_dma_num", dma_num_trans, 0);
    chk("rst_dma_addr", dma_start_addr, 0);
    chk("rst_done", {rq0_done_o, rq1_done_o}, 0);

    // T1: single request, 2-cycle issue latency, routing only to port 0
    v0 = n_vld0; v1 = n_vld1;
    req(0, 16, 32'h0); tick(); rq0_start = 0;
    chk("t1_pending", rq0_pending, 1);
    chk("t1_no_early_start", dma_start, 0);
    tick();
    chk("t1_start_2cyc", dma_start, 1);
    xfer(0, 16, 32'h0, 0, 0, 0);
    chk("t1_vld0_beats", n_vld0 - v0, 16);
    chk("t1_vld1_beats", n_vld1 - v1, 0);

    // T2: simultaneous requests after reset, port 0 first
    do_reset();
    s0 = n_start;
    req(0, 4, 32'h100); req(1, 8, 32'h200); tick(); rq0_start = 0; rq1_start = 0;
    xfer(0, 4, 32'h100, 0, 0, 0);
    xfer(1, 8, 32'h200, 0, 0, 0);
    tick(); tick(); tick();
    chk("t2_start_pulses", n_start - s0, 2);

    // T3: both ports kept busy; each re-arms on its own done, so grants must alternate
    req(0, 2, 32'h1000); req(1, 3, 32'h2000); tick(); rq0_start = 0; rq1_start = 0;
    xfer(0, 2, 32'h1000, 1, 4, 32'h1100);
    xfer(1, 3, 32'h2000, 1, 5, 32'h2100);
    xfer(0, 4, 32'h1100, 1, 6, 32'h1200);
    xfer(1, 5, 32'h2100, 1, 7, 32'h2200);
    xfer(0, 6, 32'h1200, 1, 8, 32'h1300);
    xfer(1, 7, 32'h2200, 1, 9, 32'h2300);
    xfer(0, 8, 32'h1300, 0, 0, 0);
    xfer(1, 9, 32'h2300, 0, 0, 0);
    chk("t3_idle_pending", {rq0_pending, rq1_pending}, 0);

    // T4: duplicate start on port 1 is flagged and dropped
    s0 = n_start; d1 = n_done1;
    req(1, 3, 32'h300); tick();
    req(1, 9, 32'h900); tick(); rq1_start = 0;
    chk("t4_err", rq1_err, 1);
    chk("t4_err_other", rq0_err, 0);
    xfer(1, 3, 32'h300, 0, 0, 0);
    chk("t4_err_clear", rq1_err, 0);
    repeat (5) tick();
    chk("t4_one_start", n_start - s0, 1);
    chk("t4_one_done", n_done1 - d1, 1);
    chk("t4_pending", rq1_pending, 0);

    // T5: zero-length request completes without the DMA
    s0 = n_start;
    req(0, 0, 32'h500); tick(); rq0_start = 0;
    chk("t5_done_early", rq0_done_o, 0);
    tick();
    chk("t5_done", rq0_done_o, 1);
    chk("t5_no_start", dma_start, 0);
    tick();
    chk("t5_pending_clr", rq0_pending, 0);
    chk("t5_done_once", rq0_done_o, 0);
    repeat (3) tick();
    chk("t5_start_count", n_start - s0, 0);

    // spurious vld/done while idle are dropped
    dma_data_vld_i = 1; dma_done_i = 1; dma_data_cnt_i = 7; #1;
    chk("spur_vld", {rq0_data_vld_o, rq1_data_vld_o}, 0);
    chk("spur_done", {rq0_done_o, rq1_done_o}, 0);
    chk("spur_cnt", {rq0_data_cnt_o, rq1_data_cnt_o}, 0);
    tick(); dma_data_vld_i = 0; dma_done_i = 0; dma_data_cnt_i = 0;
    chk("spur_no_start", dma_start, 0);

    // T6: reset in the middle of a transfer, then a fresh port 1 request
    req(0, 16, 32'h40); tick(); rq0_start = 0; tick();
    chk("t6_start", dma_start, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      dma_data_vld_i = 1; dma_data_cnt_i = 18'(i + 1); tick();
    end
    dma_data_cnt_i = 6; rst = 1; tick(); rst = 0;
    chk("t6_pending", {rq0_pending, rq1_pending}, 0);
    chk("t6_vld", {rq0_data_vld_o, rq1_data_vld_o}, 0);
    chk("t6_cnt", rq0_data_cnt_o, 0);
    chk("t6_dma_start", dma_start, 0);
    chk("t6_dma_num", dma_num_trans, 0);
    chk("t6_dma_addr", dma_start_addr, 0);
    chk("t6_done", {rq0_done_o, rq1_done_o}, 0);
    dma_data_vld_i = 0; dma_data_cnt_i = 0; tick();
    s0 = n_start;
    req(1, 2, 32'h80); tick(); rq1_start = 0;
    xfer(1, 2, 32'h80, 0, 0, 0);
    repeat (4) tick();
    chk("t6_one_start", n_start - s0, 1);
    chk("t6_pending_end", {rq0_pending, rq1_pending}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
